// File: rtl/syn_debug_probe_pkg.sv
// syn_debug_probe_pkg: shared widths, record-space codes and scan-length helper; DEBUG_PROBE_DM_EN enables the data-memory section
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 8
`endif
`ifndef DBG_SPACE_PC
`define DBG_SPACE_PC 2'd0
`endif
`ifndef DBG_SPACE_RF
`define DBG_SPACE_RF 2'd1
`endif
`ifndef DBG_SPACE_DM
`define DBG_SPACE_DM 2'd2
`endif
`ifndef DBG_INDEX_BIT
`define DBG_INDEX_BIT 16
`endif

package syn_debug_probe_pkg;
  localparam int DM_AW = `DM_ADDR_BIT;
  localparam int IW = `DBG_INDEX_BIT;
  localparam int NUM_REGS = 32;
`ifdef DEBUG_PROBE_DM_EN
  localparam bit DM_EN = 1'b1;
`else
  localparam bit DM_EN = 1'b0;
`endif

  // Record number of the final record: PC is 0, registers 1..32, then DM words.
  function automatic int last_rec(int dm_words);
    return DM_EN ? NUM_REGS + dm_words : NUM_REGS;
  endfunction
endpackage

// File: rtl/syn_debug_probe.sv
// syn_debug_probe: freezes the core and streams PC, registers and a DM window as records; DEBUG_PROBE_DM_EN enables the DM section
module syn_debug_probe
  import syn_debug_probe_pkg::*;
#(
  parameter int DmBase = 0,
  parameter int DmWords = 16,
  parameter bit AutoOnHalt = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    cpu_halt,
  input  logic [31:0]             pc_dbg,
  output logic [4:0]              regfile_req_dbg,
  input  logic [31:0]             regfile_data_dbg,
  output logic [`DM_ADDR_BIT-1:0] datamem_addr_dbg,
  input  logic [31:0]             datamem_data_dbg,
  output logic                    hold_cpu,
  output logic                    busy,
  output logic                    done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_space,
  output logic [IW-1:0]           out_index,
  output logic [31:0]             out_data
);
  typedef enum logic [2:0] {IDLE, ADDR, CAPT, SEND, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(last_rec(DmWords));

  state_t state, state_n;
  logic [IW-1:0] k, k_n;
  logic [DM_AW-1:0] dm_addr, dm_n;
  logic [4:0] rf_n;
  logic [31:0] dm_data;
  logic halt_q, go, fire, last, load;

`ifdef DEBUG_PROBE_DM_EN
  assign dm_data = datamem_data_dbg;
`else
  logic unused_dm;
  assign unused_dm = ^datamem_data_dbg;
  assign dm_data = 32'd0;
`endif

  assign go = start | (AutoOnHalt & cpu_halt & ~halt_q);
  assign fire = out_valid & out_ready;
  assign last = k == LAST;
  assign rf_n = 5'(k_n - IW'(1));
  assign dm_n = DM_AW'(DmBase + int'(k_n) - 33);
  assign busy = state != IDLE;
  assign hold_cpu = busy;
  assign done = state == DONE;
  assign datamem_addr_dbg = dm_addr;

  // Next state, next record number, and whether the debug addresses reload
  always_comb begin
    state_n = state;
    k_n = k;
    load = 1'b0;
    case (state)
      IDLE: if (go) begin
        state_n = ADDR;
        k_n = '0;
        load = 1'b1;
      end
      ADDR: state_n = CAPT;
      CAPT: state_n = SEND;
      SEND: if (fire) begin
        state_n = last ? DONE : ADDR;
        k_n = last ? k : k + IW'(1);
        load = ~last;
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state, record counter and halt edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      halt_q <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      halt_q <= cpu_halt;
    end
  end

  // Debug addresses load on entry to ADDR so data has a full cycle to settle before capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regfile_req_dbg <= '0;
      dm_addr <= '0;
    end else begin
      if (load && k_n != '0 && k_n <= IW'(NUM_REGS)) regfile_req_dbg <= rf_n;
      if (DM_EN && load && k_n > IW'(NUM_REGS)) dm_addr <= dm_n;
    end
  end

  // Output record slice: captured in CAPT, frozen until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_space <= '0;
      out_index <= '0;
      out_data <= '0;
    end else if (state == CAPT) begin
      out_valid <= 1'b1;
      out_space <= k == '0 ? `DBG_SPACE_PC : k <= IW'(NUM_REGS) ? `DBG_SPACE_RF : `DBG_SPACE_DM;
      out_index <= k == '0 ? '0 : k <= IW'(NUM_REGS) ? k - IW'(1) : IW'(dm_addr);
      out_data <= k == '0 ? pc_dbg : k <= IW'(NUM_REGS) ? regfile_data_dbg : dm_data;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_syn_debug_probe.sv
// tb_syn_debug_probe: table-driven and random scans of syn_debug_probe against a record-list model; honours DEBUG_PROBE_DM_EN
module tb_syn_debug_probe;
  import syn_debug_probe_pkg::*;

  localparam int AW = `DM_ADDR_BIT;
  localparam int DEPTH = 1 << AW;
  localparam int NW = 4;
  localparam int WB = DEPTH - 2;
`ifdef DEBUG_PROBE_DM_EN
  localparam int NDM = NW;
`else
  localparam int NDM = 0;
`endif
  localparam int SCAN = 3 * (33 + NDM) + 1;

  typedef struct {logic [1:0] space; int index; logic [31:0] data;} rec_t;
  typedef struct {bit use_halt; bit directed; int ready_pct; int exp_cycles;} vec_t;

  logic clk = 0, rst_n = 0, start = 0, cpu_halt = 0, out_ready = 1;
  logic [31:0] pc_dbg = 0;
  logic [4:0] rf_req_a, rf_req_w;
  logic [31:0] rf_data_a, rf_data_w, dm_data_a, dm_data_w, data_a, data_w;
  logic [AW-1:0] dm_addr_a, dm_addr_w;
  logic hold_a, busy_a, done_a, valid_a, hold_w, busy_w, done_w, valid_w;
  logic [1:0] space_a, space_w;
  logic [15:0] index_a, index_w;

  logic [31:0] rf_mem[32];
  logic [31:0] dm_mem[DEPTH];
  rec_t got_a[$], got_w[$];
  int errors = 0, checks = 0, done_cnt = 0;
  bit dm_bad = 0, pv = 0, prev_rst = 0;
  logic [49:0] pr;
  vec_t vecs[4];

  always #5 clk = ~clk;

  assign rf_data_a = rf_mem[rf_req_a];
  assign rf_data_w = rf_mem[rf_req_w];
  assign dm_data_a = dm_mem[dm_addr_a];
  assign dm_data_w = dm_mem[dm_addr_w];

  syn_debug_probe #(.DmBase(0), .DmWords(NW), .AutoOnHalt(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_halt(cpu_halt), .pc_dbg(pc_dbg),
    .regfile_req_dbg(rf_req_a), .regfile_data_dbg(rf_data_a),
    .datamem_addr_dbg(dm_addr_a), .datamem_data_dbg(dm_data_a),
    .hold_cpu(hold_a), .busy(busy_a), .done(done_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_space(space_a), .out_index(index_a), .out_data(data_a));

  syn_debug_probe #(.DmBase(WB), .DmWords(NW), .AutoOnHalt(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start), .cpu_halt(cpu_halt), .pc_dbg(pc_dbg),
    .regfile_req_dbg(rf_req_w), .regfile_data_dbg(rf_data_w),
    .datamem_addr_dbg(dm_addr_w), .datamem_data_dbg(dm_data_w),
    .hold_cpu(hold_w), .busy(busy_w), .done(done_w), .out_valid(valid_w), .out_ready(out_ready),
    .out_space(space_w), .out_index(index_w), .out_data(data_w));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record collection, stall stability and debug-address sanity, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && prev_rst && pv) chk("stall_stable", {13'd0, valid_a, space_a, index_a, data_a}, {13'd0, 1'b1, pr});
    if (rst_n && valid_a && out_ready) got_a.push_back('{space_a, int'(index_a), data_a});
    if (rst_n && valid_w && out_ready) got_w.push_back('{space_w, int'(index_w), data_w});
    if (done_a) done_cnt++;
`ifdef DEBUG_PROBE_DM_EN
    if (valid_a && space_a == 2'd2 && index_a != 16'(dm_addr_a)) dm_bad = 1;
    if (valid_w && space_w == 2'd2 && index_w != 16'(dm_addr_w)) dm_bad = 1;
`else
    if (dm_addr_a != 0 || dm_addr_w != 0) dm_bad = 1;
`endif
    pv = valid_a && !out_ready;
    pr = {space_a, index_a, data_a};
    prev_rst = rst_n;
  end

  task automatic fill(input bit directed);
    pc_dbg = directed ? 32'h40 : $urandom;
    for (int r = 0; r < 32; r++) rf_mem[r] = directed ? r * 32'h11 : $urandom;
    for (int a = 0; a < DEPTH; a++) dm_mem[a] = directed ? 32'hA000_0000 + a : $urandom;
  endtask

  task automatic check_scan(input string tag, input int base, input bit wrap);
    rec_t e[$];
    rec_t g;
    int n;
    e.push_back('{2'd0, 0, pc_dbg});
    for (int r = 0; r < 32; r++) e.push_back('{2'd1, r, rf_mem[r]});
    for (int i = 0; i < NDM; i++) e.push_back('{2'd2, (base + i) % DEPTH, dm_mem[(base + i) % DEPTH]});
    n = wrap ? got_w.size() : got_a.size();
    chk({tag, "_count"}, 64'(n), 64'(e.size()));
    for (int i = 0; i < e.size() && i < n; i++) begin
      if (wrap) g = got_w[i];
      else g = got_a[i];
      chk($sformatf("%s_rec%0d", tag, i), {14'd0, g.space, 16'(g.index), g.data},
          {14'd0, e[i].space, 16'(e[i].index), e[i].data});
    end
  endtask

  task automatic wait_done(input int pct, inout int cyc);
    while (!done_a && cyc < 5000) begin
      out_ready = $urandom_range(99) < pct;
      tick();
      cyc++;
    end
    chk("done_seen", 64'(done_a), 64'd1);
  endtask

  task automatic run_scan(input bit use_halt, input int pct, output int cyc);
    got_a.delete();
    got_w.delete();
    done_cnt = 0;
    out_ready = 1;
    if (use_halt) cpu_halt = 1;
    else start = 1;
    tick();
    start = 0;
    cyc = 1;
    wait_done(pct, cyc);
    tick();
    chk("idle_after", {61'd0, busy_a, hold_a, done_a}, 64'd0);
    chk("done_once", 64'(done_cnt), 64'd1);
    cpu_halt = 0;
    out_ready = 1;
    tick();
  endtask

  initial begin
    int cyc, n;
    bit seen;
    vecs[0] = '{1'b0, 1'b1, 100, SCAN};
    vecs[1] = '{1'b0, 1'b0, 60, -1};
    vecs[2] = '{1'b1, 1'b0, 100, SCAN};
    vecs[3] = '{1'b1, 1'b0, 35, -1};
    fill(1);
    tick();
    tick();
    chk("reset_outs", {rf_req_a, dm_addr_a, hold_a, busy_a, done_a, valid_a, space_a, index_a, data_a}, 64'd0);
    rst_n = 1;
    seen = 0;
    repeat (100) begin
      tick();
      if (valid_a || busy_a || hold_a) seen = 1;
    end
    chk("idle_quiet", 64'(seen), 64'd0);

    for (int i = 0; i < 4; i++) begin
      fill(vecs[i].directed);
      run_scan(vecs[i].use_halt, vecs[i].ready_pct, cyc);
      if (vecs[i].exp_cycles >= 0) chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cycles));
      check_scan($sformatf("v%0d", i), 0, 0);
      check_scan($sformatf("v%0d_wrap", i), WB, 1);
    end

    fill(1);
    got_a.delete();
    got_w.delete();
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (!(valid_a && space_a == 2'd1 && index_a == 16'd4) && n < 100) begin
      tick();
      n++;
    end
    chk("bp_reach", 64'(n < 100), 64'd1);
    out_ready = 0;
    repeat (10) begin
      tick();
      chk("bp_hold", {13'd0, valid_a, space_a, index_a, data_a}, {13'd0, 1'b1, 2'd1, 16'd4, 32'h44});
    end
    out_ready = 1;
    tick();
    n = 1;
    while (!valid_a && n < 10) begin
      tick();
      n++;
    end
    chk("bp_resume_lat", 64'(n), 64'd3);
    chk("bp_next", {14'd0, space_a, index_a, data_a}, {14'd0, 2'd1, 16'd5, 32'h55});
    cyc = 0;
    wait_done(100, cyc);
    tick();
    check_scan("bp", 0, 0);

    fill(0);
    got_a.delete();
    done_cnt = 0;
    cpu_halt = 1;
    tick();
    chk("auto_busy", 64'(busy_a), 64'd1);
    start = 1;
    tick();
    start = 0;
    cyc = 2;
    wait_done(100, cyc);
    chk("auto_len", 64'(cyc), 64'(SCAN));
    seen = 0;
    repeat (6) begin
      tick();
      if (busy_a) seen = 1;
    end
    chk("auto_no_requeue", 64'(seen), 64'd0);
    chk("auto_done_once", 64'(done_cnt), 64'd1);
    check_scan("auto", 0, 0);
    cpu_halt = 0;
    tick();

    fill(0);
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (!(valid_a && space_a == 2'd1 && index_a == 16'd9) && n < 100) begin
      tick();
      n++;
    end
    chk("rst_reach", 64'(n < 100), 64'd1);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rst_outs", {rf_req_a, dm_addr_a, hold_a, busy_a, done_a, valid_a, space_a, index_a, data_a}, 64'd0);
    seen = 0;
    repeat (3) begin
      tick();
      if (busy_a || valid_a) seen = 1;
    end
    chk("rst_stays_idle", 64'(seen), 64'd0);
    run_scan(0, 70, cyc);
    check_scan("replay", 0, 0);
    check_scan("replay_wrap", WB, 1);

    chk("dm_addr_rule", 64'(dm_bad), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/syn_debug_probe.md
# syn_debug_probe

Debug readback engine that sits beside the CPU top and drives the other end of its debug port: it walks the PC, all 32 registers and a window of data memory through the debug request/data pins, freezing the core while doing so. Each read word is emitted as one record on a valid/ready stream for a UART or display front end. A scan starts on an explicit request or automatically when the core halts.

## Interface
Parameters:
- DmBase, 0: first data-memory word address scanned.
- DmWords, 16: number of data-memory words scanned; 0 to 2^`DM_ADDR_BIT`.
- AutoOnHalt, 1: when 1, a rising edge of cpu_halt starts a scan.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  scan request, sampled in IDLE only.
- cpu_halt  in  1  core halt flag.
- pc_dbg  in  32  core byte PC.
- regfile_req_dbg  out  5  register-file debug read index.
- regfile_data_dbg  in  32  register-file debug read data.
- datamem_addr_dbg  out  `DM_ADDR_BIT`  data-memory debug word address.
- datamem_data_dbg  in  32  data-memory debug read data.
- hold_cpu  out  1  high while scanning; ANDed low into the core's en.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes.
- out_valid  out  1  record valid.
- out_ready  in  1  consumer accepts record.
- out_space  out  2  record space: 0 PC, 1 register, 2 data memory.
- out_index  out  16  register number or DM word address, zero-extended.
- out_data  out  32  record payload.

## Operation
- States: IDLE, ADDR, CAPT, SEND, DONE.
- IDLE: start=1, or AutoOnHalt=1 and cpu_halt rising (registered halt_q=0, cpu_halt=1), goes to ADDR with record counter k=0. Both in the same cycle start one scan.
- Record order: k=0 PC (index 0); k=1..32 register k-1; k=33..32+DmWords DM word (DmBase+k-33) mod 2^`DM_ADDR_BIT`.
- ADDR: debug addresses for record k are registered and held stable; go to CAPT.
- CAPT: selected debug data captured into out_data, space/index into out_space/out_index; out_valid set; go to SEND.
- SEND: out_* frozen while out_valid=1 and out_ready=0. On out_valid and out_ready: out_valid cleared; last record goes to DONE, otherwise k+1 and ADDR.
- DONE: done=1 for exactly this cycle; go to IDLE.
- busy and hold_cpu are 1 in ADDR, CAPT, SEND and DONE, and 0 in IDLE.
- start while not IDLE is ignored; a halt edge while busy does not requeue.
- DmWords=0: register 31 is the last record.
- Reset (any state, mid-record included): next edge forces IDLE. All outputs and registers go to 0, halt_q included. A record pending in SEND is dropped.

## Timing
- Edge e0 samples start: ADDR after e0, CAPT after e1, out_valid high after e2.
- With out_ready tied high: 3 cycles per record; full scan is 3*(33+DmWords)+1 cycles including DONE.
- Debug data is sampled one full cycle after its address is registered. Combinational or single-registered debug reads are both valid.
- hold_cpu rises the cycle after start is sampled. The core therefore executes at most one more instruction. The PC record reflects the state after that instruction.
- Reset values: every output 0.

## Configuration
- DEBUG_PROBE_DM_EN defined: data-memory section scanned as above.
- Undefined: DmWords is ignored. Register 31 is the last record. datamem_addr_dbg is tied to 0 and datamem_data_dbg is unused. Scan is 100 cycles.

## Structure
- Core.vh gains `DBG_SPACE_PC`, `DBG_SPACE_RF`, `DBG_SPACE_DM` (2-bit) and `DBG_INDEX_BIT` (16).
- FSM state encoding stays local to the module.
- No sub-module: counter, FSM and output register slice are flat in one module.

## Test plan
- Idle: after reset, all outputs 0. start=0 with cpu_halt=0 for 100 cycles -> out_valid, busy, hold_cpu stay 0.
- Full scan: pc_dbg=0x0000_0040, register r returns r*0x11, DM word a returns 0xA000_0000+a, DmWords=4, out_ready=1. Require 37 records in order: (0,0,0x40), (1,0..31,r*0x11), (2,0..3,0xA000_0000..0xA000_0003). done pulses once, 112 cycles after start.
- Backpressure: hold out_ready=0 for 10 cycles on record 5 -> out_data 0x44, out_index 4, out_space 1 stay stable. Record 6 appears 3 cycles after out_ready returns.
- Auto start: AutoOnHalt=1, cpu_halt 0->1 -> busy next cycle. cpu_halt held high, or a second start while busy -> no second scan.
- Reset mid-scan: rst_n=0 for one cycle during SEND of record 10 -> next cycle all outputs 0 and IDLE. A new start replays from the PC record.
- Wrap: DmBase=2^`DM_ADDR_BIT`-2, DmWords=4 -> DM indices max-1, max, 0, 1. Without DEBUG_PROBE_DM_EN -> 33 records and datamem_addr_dbg always 0.
